// File: rtl/sample_scheduler.sv
// Round-robin sampling sequencer: strobes each unit in the table, stores changed
// samples as {unit id, sample} in a circular RAM FIFO, and tracks the readout pointers.
module sample_scheduler #(
  parameter int MAX_UNITS = 16,
  parameter int ID_W      = 6,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int TIMEOUT   = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   cfg_wr,
  input  logic [ID_W-1:0]        cfg_id,
  input  logic                   cfg_clear,
  output logic [2**ID_W-1:0]     unit_enable,
  input  logic                   sample_valid,
  input  logic [DATA_W-1:0]      sample_data,
  output logic                   ram_we,
  output logic [ADDR_W-1:0]      ram_waddr,
  output logic [ID_W+DATA_W-1:0] ram_wdata,
  output logic [ADDR_W-1:0]      ram_raddr,
  input  logic                   pop,
  output logic [ADDR_W:0]        num_samples,
  output logic                   full,
  output logic                   overflow,
  output logic                   timeout_err,
  output logic [2:0]             dbg_state
);

  localparam int SLOT_W = $clog2(MAX_UNITS);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  // dbg_state encoding: 0 IDLE, 1 ENABLE, 2 WAIT, 3 STORE, 4 NEXT
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ENABLE = 3'd1,
    S_WAIT   = 3'd2,
    S_STORE  = 3'd3,
    S_NEXT   = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [SLOT_W-1:0]        slot_q, slot_d;
  logic [SLOT_W:0]          num_units_q, num_units_d;
  logic [ID_W-1:0]          tbl_q [MAX_UNITS];
  logic [ID_W-1:0]          tbl_d [MAX_UNITS];
  logic [DATA_W-1:0]        last_q [MAX_UNITS];
  logic [DATA_W-1:0]        last_d [MAX_UNITS];
  logic [MAX_UNITS-1:0]     last_valid_q, last_valid_d;
  logic [DATA_W-1:0]        sample_q, sample_d;
  logic [CNT_W-1:0]         wait_cnt_q, wait_cnt_d;
  logic [2**ID_W-1:0]       unit_enable_q, unit_enable_d;
  logic                     ram_we_q, ram_we_d;
  logic [ID_W+DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]          count_q, count_d;
  logic                     overflow_q, overflow_d;
  logic                     timeout_err_q, timeout_err_d;

  logic                     want_write;
  logic                     pop_ok;
  logic                     is_full;
  logic [SLOT_W:0]          slot_inc;

  // Handshakes: sample_valid is a one-cycle qualifier for sample_data and is only
  // accepted in WAIT; pop is a one-cycle pulse consuming the entry at rd_ptr and is
  // accepted only when at least one entry is held (no back-pressure on either side).
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    num_units_d   = num_units_q;
    tbl_d         = tbl_q;
    last_d        = last_q;
    last_valid_d  = last_valid_q;
    sample_d      = sample_q;
    wait_cnt_d    = wait_cnt_q;
    ram_we_d      = 1'b0;
    ram_wdata_d   = ram_wdata_q;
    overflow_d    = overflow_q;
    timeout_err_d = timeout_err_q;
    want_write    = 1'b0;
    is_full       = (count_q == DEPTH);
    slot_inc      = {1'b0, slot_q} + (SLOT_W+1)'(1);

    if (cfg_clear) begin
      num_units_d  = '0;
      slot_d       = '0;
      last_valid_d = '0;
      state_d      = S_IDLE;
    end else begin
      if (cfg_wr && num_units_q != (SLOT_W+1)'(MAX_UNITS)) begin
        tbl_d[num_units_q[SLOT_W-1:0]] = cfg_id;
        num_units_d = num_units_q + (SLOT_W+1)'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (run && num_units_q != '0) state_d = S_ENABLE;
        end
        S_ENABLE: begin
          wait_cnt_d = CNT_W'(1);
          state_d    = S_WAIT;
        end
        S_WAIT: begin
          if (sample_valid) begin
            sample_d = sample_data;
            state_d  = S_STORE;
          end else if (wait_cnt_q == CNT_W'(TIMEOUT)) begin
            timeout_err_d = 1'b1;
            state_d       = S_NEXT;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end
        S_STORE: begin
          want_write           = !last_valid_q[slot_q] || (sample_q != last_q[slot_q]);
          last_d[slot_q]       = sample_q;
          last_valid_d[slot_q] = 1'b1;
          if (want_write) begin
            if (is_full) begin
              overflow_d = 1'b1;
            end else begin
              ram_we_d    = 1'b1;
              ram_wdata_d = {tbl_q[slot_q], sample_q};
            end
          end
          state_d = S_NEXT;
        end
        S_NEXT: begin
          slot_d  = (slot_inc == num_units_q) ? '0 : slot_inc[SLOT_W-1:0];
          state_d = run ? S_ENABLE : S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Strobe is registered so it is high exactly during the ENABLE cycle.
    unit_enable_d = '0;
    if (state_d == S_ENABLE) unit_enable_d[tbl_q[slot_d]] = 1'b1;

    // The write commits in the cycle ram_we is high, so ram_waddr still shows wr_ptr.
    pop_ok   = pop && (count_q != '0);
    wr_ptr_d = ram_we_q ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok   ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (ram_we_q && !pop_ok)      count_d = count_q + (ADDR_W+1)'(1);
    else if (!ram_we_q && pop_ok) count_d = count_q - (ADDR_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      slot_q        <= '0;
      num_units_q   <= '0;
      last_valid_q  <= '0;
      sample_q      <= '0;
      wait_cnt_q    <= '0;
      unit_enable_q <= '0;
      ram_we_q      <= 1'b0;
      ram_wdata_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      num_units_q   <= num_units_d;
      last_valid_q  <= last_valid_d;
      sample_q      <= sample_d;
      wait_cnt_q    <= wait_cnt_d;
      unit_enable_q <= unit_enable_d;
      ram_we_q      <= ram_we_d;
      ram_wdata_q   <= ram_wdata_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Table and sample history are qualified by num_units / last_valid, so no reset needed.
  always_ff @(posedge clk) begin
    tbl_q  <= tbl_d;
    last_q <= last_d;
  end

  assign unit_enable = unit_enable_q;
  assign ram_we      = ram_we_q;
  assign ram_waddr   = wr_ptr_q;
  assign ram_wdata   = ram_wdata_q;
  assign ram_raddr   = rd_ptr_q;
  assign num_samples = count_q;
  assign full        = (count_q == DEPTH);
  assign overflow    = overflow_q;
  assign timeout_err = timeout_err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sample_scheduler.sv
// Directed bench for sample_scheduler with a 4-entry FIFO (ADDR_W=2) so wrap,
// full and overflow are reachable in a few sweeps.
module tb_sample_scheduler;

  localparam int ID_W   = 6;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 2;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_NEXT = 3'd4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   run = 1'b0;
  logic                   cfg_wr = 1'b0;
  logic [ID_W-1:0]        cfg_id = '0;
  logic                   cfg_clear = 1'b0;
  logic [2**ID_W-1:0]     unit_enable;
  logic                   sample_valid = 1'b0;
  logic [DATA_W-1:0]      sample_data = '0;
  logic                   ram_we;
  logic [ADDR_W-1:0]      ram_waddr;
  logic [ID_W+DATA_W-1:0] ram_wdata;
  logic [ADDR_W-1:0]      ram_raddr;
  logic                   pop = 1'b0;
  logic [ADDR_W:0]        num_samples;
  logic                   full;
  logic                   overflow;
  logic                   timeout_err;
  logic [2:0]             dbg_state;

  int checks = 0;
  int errors = 0;

  sample_scheduler #(
    .MAX_UNITS(16), .ID_W(ID_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(15)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .cfg_wr(cfg_wr), .cfg_id(cfg_id),
    .cfg_clear(cfg_clear), .unit_enable(unit_enable), .sample_valid(sample_valid),
    .sample_data(sample_data), .ram_we(ram_we), .ram_waddr(ram_waddr),
    .ram_wdata(ram_wdata), .ram_raddr(ram_raddr), .pop(pop),
    .num_samples(num_samples), .full(full), .overflow(overflow),
    .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] onehot(input logic [5:0] id);
    logic [63:0] one;
    one = 64'd1;
    return one << id;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_add(input logic [5:0] id);
    cfg_wr = 1'b1;
    cfg_id = id;
    tick();
    cfg_wr = 1'b0;
  endtask

  // One full slot: waits for the strobe, answers in the first WAIT cycle, checks the
  // write in the NEXT cycle, then applies pop/run for the NEXT->ENABLE/IDLE edge.
  task automatic serve(input string tag, input logic [5:0] id, input logic [15:0] data,
                       input logic exp_we, input logic [1:0] exp_addr, input logic pop_n,
                       input logic run_after, input logic [2:0] exp_cnt);
    int n;
    n = 0;
    while (unit_enable == '0 && n < 40) begin
      tick();
      n++;
    end
    check({tag, " enable"}, unit_enable, onehot(id));
    tick();
    sample_valid = 1'b1;
    sample_data  = data;
    tick();
    sample_valid = 1'b0;
    tick();
    check({tag, " state_next"}, dbg_state, ST_NEXT);
    check({tag, " ram_we"}, ram_we, exp_we);
    if (exp_we) begin
      check({tag, " wdata"}, ram_wdata, {id, data});
      check({tag, " waddr"}, ram_waddr, exp_addr);
    end
    pop = pop_n;
    run = run_after;
    tick();
    pop = 1'b0;
    check({tag, " count"}, num_samples, exp_cnt);
  endtask

  initial begin
    int n;

    // reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst enable", unit_enable, 0);
    check("rst ram_we", ram_we, 0);
    check("rst count", num_samples, 0);
    check("rst full", full, 0);
    check("rst overflow", overflow, 0);
    check("rst timeout", timeout_err, 0);
    check("rst raddr", ram_raddr, 0);
    check("rst state", dbg_state, ST_IDLE);

    // unchanged samples are written once per unit
    cfg_add(6'd3);
    cfg_add(6'd7);
    run = 1'b1;
    serve("t1a", 6'd3, 16'h00A5, 1'b1, 2'd0, 1'b0, 1'b1, 3'd1);
    serve("t1b", 6'd7, 16'h00A5, 1'b1, 2'd1, 1'b0, 1'b1, 3'd2);
    serve("t1c", 6'd3, 16'h00A5, 1'b0, 2'd0, 1'b0, 1'b1, 3'd2);
    serve("t1d", 6'd7, 16'h00A5, 1'b0, 2'd0, 1'b0, 1'b0, 3'd2);
    check("t1 idle", dbg_state, ST_IDLE);
    check("t1 enable off", unit_enable, 0);
    pop = 1'b1;
    tick();
    check("pop1 count", num_samples, 1);
    check("pop1 raddr", ram_raddr, 1);
    tick();
    check("pop2 count", num_samples, 0);
    check("pop2 raddr", ram_raddr, 2);
    tick();
    pop = 1'b0;
    check("pop empty count", num_samples, 0);
    check("pop empty raddr", ram_raddr, 2);

    // changing samples with same-cycle pop: count holds at 1, pointers wrap
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
    cfg_add(6'd3);
    run = 1'b1;
    serve("t2a", 6'd3, 16'h0001, 1'b1, 2'd2, 1'b0, 1'b1, 3'd1);
    serve("t2b", 6'd3, 16'h0002, 1'b1, 2'd3, 1'b1, 1'b1, 3'd1);
    check("t2b raddr", ram_raddr, 3);
    serve("t2c", 6'd3, 16'h0001, 1'b1, 2'd0, 1'b1, 1'b1, 3'd1);
    check("t2c raddr", ram_raddr, 0);
    serve("t2d", 6'd3, 16'h0002, 1'b1, 2'd1, 1'b1, 1'b0, 3'd1);
    check("t2d raddr", ram_raddr, 1);

    // fill to full, then a dropped change sets overflow but still updates history
    run = 1'b1;
    serve("t3a", 6'd3, 16'h0001, 1'b1, 2'd2, 1'b0, 1'b1, 3'd2);
    serve("t3b", 6'd3, 16'h0002, 1'b1, 2'd3, 1'b0, 1'b1, 3'd3);
    serve("t3c", 6'd3, 16'h0001, 1'b1, 2'd0, 1'b0, 1'b1, 3'd4);
    check("t3 full", full, 1);
    check("t3 no overflow yet", overflow, 0);
    serve("t3d", 6'd3, 16'h0002, 1'b0, 2'd0, 1'b0, 1'b1, 3'd4);
    check("t3 overflow", overflow, 1);
    serve("t3e", 6'd3, 16'h0002, 1'b0, 2'd0, 1'b1, 1'b0, 3'd3);
    check("t3 not full", full, 0);
    check("t3 overflow sticky", overflow, 1);

    // silent unit times out after 15 WAIT cycles; next slot still served
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
    cfg_add(6'd5);
    cfg_add(6'd9);
    run = 1'b1;
    n = 0;
    while (unit_enable == '0 && n < 40) begin
      tick();
      n++;
    end
    check("t4 enable5", unit_enable, onehot(6'd5));
    tick();
    check("t4 timeout clear", timeout_err, 0);
    n = 0;
    while (dbg_state == ST_WAIT && n < 40) begin
      tick();
      n++;
    end
    check("t4 wait cycles", n, 15);
    check("t4 timeout set", timeout_err, 1);
    check("t4 state next", dbg_state, ST_NEXT);
    tick();
    serve("t4b", 6'd9, 16'h1234, 1'b1, 2'd1, 1'b0, 1'b0, 3'd4);

    // drain, then 17 appends: only 16 slots accepted
    pop = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    pop = 1'b0;
    check("t5 drained", num_samples, 0);
    check("t5 raddr", ram_raddr, 2);
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
    for (int i = 0; i < 17; i++) cfg_add(6'(10 + i));
    run = 1'b1;
    for (int i = 0; i < 16; i++) begin
      serve($sformatf("t5 slot%0d", i), 6'(10 + i), 16'(i), (i < 4),
            2'((2 + i) % 4), 1'b0, 1'b1, 3'((i < 4) ? i + 1 : 4));
    end
    check("t5 wrap to slot0", unit_enable, onehot(6'd10));
    tick();
    check("t5 in wait", dbg_state, ST_WAIT);
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
    check("t5 clear enable", unit_enable, 0);
    check("t5 clear idle", dbg_state, ST_IDLE);
    check("t5 clear count", num_samples, 4);
    tick();
    check("t5 stays idle", dbg_state, ST_IDLE);
    run = 1'b0;
    pop = 1'b1;
    tick();
    pop = 1'b0;
    cfg_add(6'd3);
    run = 1'b1;
    serve("t5 readd", 6'd3, 16'h0000, 1'b1, 2'd2, 1'b0, 1'b0, 3'd4);

    // reset in the middle of a sweep
    run = 1'b1;
    tick();
    check("t7 enable3", unit_enable, onehot(6'd3));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t7 enable off", unit_enable, 0);
    check("t7 ram_we off", ram_we, 0);
    check("t7 count", num_samples, 0);
    check("t7 overflow", overflow, 0);
    check("t7 timeout", timeout_err, 0);
    check("t7 state", dbg_state, ST_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
